// File: rtl/led_afterglow_driver.sv
// Output stage that gives every pattern LED an afterglow: a lit bit shows full brightness
// at once, and a dropped bit fades out through per-channel PWM.
module led_afterglow_driver #(
  parameter int PWM_BITS     = 4,
  parameter int DECAY_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] pat,
  input  logic       fade_en,
  output logic [7:0] led,
  output logic       active
);

  localparam int PRE_W = $clog2(DECAY_CYCLES);

  localparam logic [PWM_BITS-1:0] BR_MAX   = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_CYCLES - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic                decay_tick;

  logic [PWM_BITS-1:0] br      [8];
  logic [PWM_BITS-1:0] br_next [8];
  logic [7:0]          led_next;
  logic                active_next;

  assign decay_tick = (pre_cnt == PRE_LAST);

  // A set pattern bit reloads full brightness and wins over a decay step in the same cycle.
  // LED and active outputs look at the brightness before this edge's update.
  always_comb begin
    led_next    = '0;
    active_next = 1'b0;
    for (int i = 0; i < 8; i++) begin
      br_next[i] = br[i];
      if (pat[i]) begin
        br_next[i] = BR_MAX;
      end else if (decay_tick && (br[i] != '0)) begin
        br_next[i] = br[i] - PWM_ONE;
      end
      led_next[i] = pat[i] | (fade_en & (br[i] > pwm_cnt));
      active_next = active_next | (br[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pwm_cnt <= '0;
      pre_cnt <= '0;
      led     <= '0;
      active  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        br[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_ONE;
      pre_cnt <= decay_tick ? '0 : (pre_cnt + PRE_ONE);
      led     <= led_next;
      active  <= active_next;
      for (int i = 0; i < 8; i++) begin
        br[i] <= br_next[i];
      end
    end
  end

endmodule
